// File: rtl/subleq_uart_tx_pkg.sv
// subleq_uart_tx_pkg
// Shared definitions for the subleq UART transmit responder:
//   - tx_state_t   : shifter FSM state encodings (2-bit)
//   - status word field positions for the status read
//   - free_count_width() : width of the free-slot field in the status word
// Optional build macro used by the users of this package: SUBLEQ_TX_WIDE_EN
package subleq_uart_tx_pkg;

    localparam int DEFAULT_WORD_SIZE = 16;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // The free-slot count sits in the low bits of the status word; the idle
    // flag sits in the most significant bit.
    localparam int STATUS_FREE_LSB = 0;

    function automatic int free_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/subleq_tx_fifo.sv
// subleq_tx_fifo
// Circular FIFO with wrapping read/write pointers and an occupancy count.
// A push while full is still accepted when a pop happens in the same cycle,
// because the pop frees the slot first.
// Ports:
//   clk, areset      : clock, asynchronous active-low reset
//   push, wr_data    : write request and data
//   pop, rd_data     : read request; rd_data shows the head word
//   full, empty      : occupancy flags
//   count            : number of stored words (0..DEPTH)
module subleq_tx_fifo
    import subleq_uart_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [free_count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = free_count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/subleq_uart_tx.sv
// subleq_uart_tx
// MMIO output responder for the subleq CPU: accepts stored words through a
// 4-phase req/ack handshake, queues them in a FIFO and sends them on a UART
// 8N1 line. A status read returns {idle, zero-pad, free slot count}.
// Ports:
//   clk    : system clock
//   areset : asynchronous active-low reset
//   req    : CPU request, held until ack
//   store  : 1 = write word, 0 = status read
//   in     : word to transmit
//   ack    : 4-phase acknowledge
//   out    : status word, valid while ack=1 on a read
//   txd    : serial line, idle high
//   idle   : FIFO empty and shifter idle (registered)
// Build macro: SUBLEQ_TX_WIDE_EN stores full words and sends low byte then
// high byte as two frames; otherwise only in[7:0] is stored and sent.
module subleq_uart_tx
    import subleq_uart_tx_pkg::*;
#(
    parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 req,
    input  logic                 store,
    input  logic [WORD_SIZE-1:0] in,
    output logic                 ack,
    output logic [WORD_SIZE-1:0] out,
    output logic                 txd,
    output logic                 idle
);

`ifdef SUBLEQ_TX_WIDE_EN
    localparam int FIFO_W = WORD_SIZE;
`else
    localparam int FIFO_W = 8;
`endif
    localparam int FREE_W = free_count_width(DEPTH);
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t          state, state_next;
    logic [BAUD_W-1:0]  baud_cnt, baud_next;
    logic [2:0]         bit_idx, bit_next;
    logic [7:0]         shift, shift_next;
    logic               txd_next;
    logic               baud_done;

    logic               fifo_pop;
    logic [FIFO_W-1:0]  fifo_rd;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FREE_W-1:0]  fifo_count;

    logic               accept_write;
    logic               accept_read;
    logic [WORD_SIZE-1:0] status_word;

`ifdef SUBLEQ_TX_WIDE_EN
    logic [7:0]         hi_byte, hi_next;
    logic               second_half, second_next;
`else
    logic               unused_high_in;
    assign unused_high_in = ^in[WORD_SIZE-1:8];
`endif

    assign baud_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    // A full FIFO can still take the word when the shifter pops this cycle.
    assign accept_write = req && store && !ack && (!fifo_full || fifo_pop);
    assign accept_read  = req && !store && !ack;

    always_comb begin
        status_word = '0;
        status_word[WORD_SIZE-1] = idle;
        status_word[STATUS_FREE_LSB +: FREE_W] = FREE_W'(DEPTH) - fifo_count;
    end

    subleq_tx_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .areset  (areset),
        .push    (accept_write),
        .wr_data (in[FIFO_W-1:0]),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Handshake: ack holds while req holds and drops the cycle after req
    // drops, so each request is serviced exactly once.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            ack <= 1'b0;
            out <= '0;
        end else if (ack) begin
            ack <= req;
            if (!req) out <= '0;
        end else if (accept_write || accept_read) begin
            ack <= 1'b1;
            out <= accept_read ? status_word : '0;
        end
    end

    // Shifter state and line driver; txd is registered from the current
    // state, which gives the two-cycle write-ack to start-bit latency.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            idle     <= 1'b1;
`ifdef SUBLEQ_TX_WIDE_EN
            hi_byte     <= '0;
            second_half <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            txd      <= txd_next;
            idle     <= (fifo_count == '0) && (state == TX_IDLE);
`ifdef SUBLEQ_TX_WIDE_EN
            hi_byte     <= hi_next;
            second_half <= second_next;
`endif
        end
    end

    // Next-state logic: every popped word enters START with a cleared baud
    // counter; STOP chains straight into the next START when more is queued.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        txd_next   = 1'b1;
        fifo_pop   = 1'b0;
`ifdef SUBLEQ_TX_WIDE_EN
        hi_next     = hi_byte;
        second_next = second_half;
`endif
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_rd[7:0];
`ifdef SUBLEQ_TX_WIDE_EN
                    hi_next     = fifo_rd[15:8];
                    second_next = 1'b0;
`endif
                    baud_next  = '0;
                    state_next = TX_START;
                end
            end
            TX_START: begin
                txd_next = 1'b0;
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = TX_DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                txd_next = shift[0];
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_next = TX_STOP;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                txd_next = 1'b1;
                if (baud_done) begin
                    baud_next = '0;
`ifdef SUBLEQ_TX_WIDE_EN
                    if (!second_half) begin
                        shift_next  = hi_byte;
                        second_next = 1'b1;
                        state_next  = TX_START;
                    end else
`endif
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_rd[7:0];
`ifdef SUBLEQ_TX_WIDE_EN
                        hi_next     = fifo_rd[15:8];
                        second_next = 1'b0;
`endif
                        state_next = TX_START;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_subleq_uart_tx.sv
// tb_subleq_uart_tx
// Self-checking bench: a UART receiver decodes txd into a queue of bytes and
// start times, which are compared with a reference queue of expected bytes
// built from the words written. Handshake, status, timing and reset
// behaviour are checked inline in each scenario task.
module tb_subleq_uart_tx;

    localparam int WORD_SIZE = 16;
    localparam int DEPTH     = 4;
    localparam int CPB       = 8;
    localparam int FRAME     = 10 * CPB;
`ifdef SUBLEQ_TX_WIDE_EN
    localparam int FRAMES_PER_WORD = 2;
`else
    localparam int FRAMES_PER_WORD = 1;
`endif

    logic                 clk = 1'b0;
    logic                 areset = 1'b0;
    logic                 req = 1'b0;
    logic                 store = 1'b0;
    logic [WORD_SIZE-1:0] in_word = '0;
    logic                 ack;
    logic [WORD_SIZE-1:0] out_word;
    logic                 txd;
    logic                 idle;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    logic [7:0] exp_q[$];
    int         framing_errs = 0;

    subleq_uart_tx #(
        .WORD_SIZE    (WORD_SIZE),
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .req    (req),
        .store  (store),
        .in     (in_word),
        .ack    (ack),
        .out    (out_word),
        .txd    (txd),
        .idle   (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: finds a start bit, then samples each bit near its centre.
    initial begin : uart_monitor
        int t0;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (areset && txd === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                if (txd === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = txd;
                    end
                    repeat (CPB) @(negedge clk);
                    if (txd !== 1'b1) framing_errs++;
                    rx_q.push_back(b);
                    start_q.push_back(t0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected bytes on the line for one written word.
    function automatic void model_write(input logic [WORD_SIZE-1:0] w);
        exp_q.push_back(w[7:0]);
`ifdef SUBLEQ_TX_WIDE_EN
        exp_q.push_back(w[15:8]);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        rx_q.delete();
        start_q.delete();
        exp_q.delete();
        framing_errs = 0;
    endtask

    task automatic applyStimulus(input logic [WORD_SIZE-1:0] w, output int ack_cyc);
        bit ok;
        ok = 1'b0;
        req = 1'b1; store = 1'b1; in_word = w;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (ack === 1'b1) begin ok = 1'b1; break; end
        end
        ack_cyc = cyc;
        req = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("[TB] FAIL write_ack_timeout: ack=%b required 1 for word %h", ack, w);
        end else begin
            model_write(w);
        end
        for (int i = 0; i < 10 && ack === 1'b1; i++) tick();
    endtask

    task automatic do_read(output logic [WORD_SIZE-1:0] st);
        bit ok;
        ok = 1'b0;
        req = 1'b1; store = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ack === 1'b1) begin ok = 1'b1; break; end
        end
        st = out_word;
        req = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("[TB] FAIL read_ack_timeout: ack=%b required 1", ack);
        end
        for (int i = 0; i < 10 && ack === 1'b1; i++) tick();
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (idle === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("[TB] FAIL idle_timeout: idle=%b required 1", idle);
        end
        repeat (2 * CPB) tick();
    endtask

    task automatic checkOutput(input string name);
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d bytes, expected %0d", name, rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL %s_byte%0d: got %h, expected %h", name, i, rx_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (framing_errs != 0) begin
            errors++;
            $display("[TB] FAIL %s_framing: got %0d stop-bit errors, expected 0", name, framing_errs);
        end
    endtask

    task automatic test_reset();
        areset = 1'b0;
        repeat (3) tick();
        checks += 4;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b, expected 0", ack); end
        if (out_word !== '0) begin errors++; $display("[TB] FAIL reset_out: got %h, expected 0000", out_word); end
        if (txd !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd: got %b, expected 1", txd); end
        if (idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got %b, expected 1", idle); end
        @(negedge clk);
        areset = 1'b1;
        repeat (4) tick();
    endtask

    // Compares the whole txd waveform of one frame against the 8N1 shape,
    // including the two-cycle latency after the ack edge.
    task automatic test_single_frame();
        logic [WORD_SIZE-1:0] w;
        logic [9:0] frame_bits;
        logic expv;
        int ack_cyc, bad, first_bad;
        bit ok;
        clear_queues();
        tick();
        w = 16'h0041;
        frame_bits = {1'b1, w[7:0], 1'b0};
        req = 1'b1; store = 1'b1; in_word = w; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack === 1'b1) begin ok = 1'b1; break; end
        end
        ack_cyc = cyc;
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL single_ack: got %b, expected 1", ack); end
        else model_write(w);
        bad = 0; first_bad = -1;
        for (int k = 0; k < FRAME + 10; k++) begin
            @(negedge clk);
            if (k == 0) req = 1'b0;
            if (k < 2 || (k - 2) / CPB >= 10) expv = 1'b1;
            else expv = frame_bits[(k - 2) / CPB];
            if (txd !== expv) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (k == 40) begin
                checks++;
                if (idle !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_idle: got %b, expected 0", idle); end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL single_waveform: %0d wrong txd samples, first at cycle ack+%0d, expected none", bad, first_bad);
        end
        repeat (4) tick();
        checks++;
        if (idle !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_after: got %b, expected 1", idle); end
        repeat (CPB) tick();
        checkOutput("single");
        checks++;
        if (start_q.size() < 1 || start_q[0] - ack_cyc != 2) begin
            errors++;
            $display("[TB] FAIL single_latency: start-ack=%0d, expected 2", start_q.size() ? start_q[0] - ack_cyc : -1);
        end
    endtask

    task automatic test_handshake();
        logic [WORD_SIZE-1:0] w;
        int held;
        bit ok;
        clear_queues();
        tick();
        w = WORD_SIZE'($urandom);
        req = 1'b1; store = 1'b1; in_word = w; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack === 1'b1) begin ok = 1'b1; break; end
        end
        if (ok) model_write(w);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack === 1'b1) held++;
        end
        checks++;
        if (held != 10) begin errors++; $display("[TB] FAIL hs_ack_held: ack high %0d of 10 cycles, expected 10", held); end
        req = 1'b0;
        checks++;
        if (ack !== 1'b1) begin errors++; $display("[TB] FAIL hs_ack_before_fall: got %b, expected 1", ack); end
        tick();
        checks++;
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL hs_ack_fall: got %b, expected 0", ack); end
        wait_idle(400);
        checkOutput("handshake");
    endtask

    task automatic test_burst();
        int ack_cyc;
        clear_queues();
        tick();
        for (int i = 0; i < 5; i++) applyStimulus(WORD_SIZE'(16'h0031 + i), ack_cyc);
        wait_idle(1000 * FRAMES_PER_WORD);
        checkOutput("burst");
        for (int i = 0; i + 1 < start_q.size(); i++) begin
            checks++;
            if (start_q[i + 1] - start_q[i] != FRAME) begin
                errors++;
                $display("[TB] FAIL burst_gap%0d: got %0d cycles, expected %0d", i, start_q[i + 1] - start_q[i], FRAME);
            end
        end
    endtask

    // Six writes: the sixth finds the FIFO full and is accepted in the cycle
    // the shifter pops the second word at the end of the first word's frames.
    task automatic test_fifo_full();
        int acks[6];
        clear_queues();
        tick();
        for (int i = 0; i < 6; i++) applyStimulus(WORD_SIZE'($urandom), acks[i]);
        checks++;
        if (acks[4] - acks[0] > 40) begin
            errors++;
            $display("[TB] FAIL full_early_acks: fifth ack %0d cycles after first, expected under 40", acks[4] - acks[0]);
        end
        wait_idle(1200 * FRAMES_PER_WORD);
        checks++;
        if (start_q.size() < 1 || acks[5] != start_q[0] + FRAMES_PER_WORD * FRAME - 1) begin
            errors++;
            $display("[TB] FAIL full_stall_ack: sixth ack at %0d, expected %0d",
                     acks[5], start_q.size() ? start_q[0] + FRAMES_PER_WORD * FRAME - 1 : -1);
        end
        checkOutput("fifo_full");
    endtask

    task automatic test_status();
        logic [WORD_SIZE-1:0] st;
        int ack_cyc;
        clear_queues();
        tick();
        for (int i = 0; i < 3; i++) applyStimulus(WORD_SIZE'($urandom), ack_cyc);
        do_read(st);
        checks++;
        if (st !== 16'h0002) begin errors++; $display("[TB] FAIL status_busy: got %h, expected 0002", st); end
        wait_idle(800 * FRAMES_PER_WORD);
        do_read(st);
        checks++;
        if (st !== 16'h8004) begin errors++; $display("[TB] FAIL status_drained: got %h, expected 8004", st); end
        checkOutput("status");
    endtask

    task automatic test_random();
        int ack_cyc;
        clear_queues();
        tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(WORD_SIZE'($urandom), ack_cyc);
            repeat ($urandom_range(0, 120)) tick();
        end
        wait_idle(1200 * FRAMES_PER_WORD);
        checkOutput("random");
    endtask

    task automatic test_reset_mid_frame();
        int ack_cyc, target, highs;
        clear_queues();
        tick();
        applyStimulus(16'h0041, ack_cyc);
        target = ack_cyc + 2 + 4 * CPB + CPB / 2;
        for (int i = 0; i < 200 && cyc < target - 3; i++) tick();
        req = 1'b1; store = 1'b1; in_word = 16'h0055;
        tick(); tick();
        @(negedge clk);
        areset = 1'b0;
        #1;
        checks += 4;
        if (txd !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_txd: got %b, expected 1", txd); end
        if (idle !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_idle: got %b, expected 1", idle); end
        if (ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ack: got %b, expected 0", ack); end
        if (out_word !== '0) begin errors++; $display("[TB] FAIL rst_mid_out: got %h, expected 0000", out_word); end
        repeat (3) tick();
        req = 1'b0;
        @(negedge clk);
        areset = 1'b1;
        highs = 0;
        for (int i = 0; i < 12 * CPB; i++) begin
            @(negedge clk);
            if (txd === 1'b1) highs++;
        end
        checks += 2;
        if (highs != 12 * CPB) begin errors++; $display("[TB] FAIL rst_mid_quiet: txd high %0d of %0d cycles, expected all", highs, 12 * CPB); end
        if (idle !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_idle_after: got %b, expected 1", idle); end
        clear_queues();
        tick();
    endtask

`ifdef SUBLEQ_TX_WIDE_EN
    task automatic test_wide();
        logic [WORD_SIZE-1:0] st;
        int ack_cyc;
        clear_queues();
        tick();
        applyStimulus(16'h4142, ack_cyc);
        for (int i = 0; i < 400 && cyc < ack_cyc + 2 + FRAME + 20; i++) tick();
        do_read(st);
        checks++;
        if (st[2:0] !== 3'(DEPTH)) begin errors++; $display("[TB] FAIL wide_free: got %0d, expected %0d", st[2:0], DEPTH); end
        wait_idle(400);
        checkOutput("wide");
    endtask
`endif

    initial begin
        $display("[TB] subleq_uart_tx bench start");
        test_reset();
        test_single_frame();
        test_handshake();
        test_burst();
        test_fifo_full();
        test_status();
        test_random();
        test_reset_mid_frame();
`ifdef SUBLEQ_TX_WIDE_EN
        test_wide();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
